// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding, default bit timing,
// default acknowledge byte and frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // clk cycles per UART bit
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  // ASCII ACK
  localparam logic [7:0]  ACK_BYTE_DEFAULT   = 8'h06;
  // start + 8 data + stop
  localparam int unsigned FRAME_BITS         = 10;

endpackage

// File: rtl/uart_ack_tx.sv
// 8N1 UART transmitter that sends a fixed ACK byte on each rising edge of ack_in and otherwise
// forwards general payload bytes through a valid/ready handshake. Pending ACKs take priority
// over payload and multiple edges coalesce into one ACK frame.
//
// Ports:
//   clk      - sampling clock, OVERSAMPLE x baud
//   rst      - asynchronous active-high reset
//   ack_in   - acknowledge level, already synchronous to clk
//   tx_data  - payload byte, sampled only in the accepting cycle
//   tx_valid - tx_data is valid
//   tx_ready - payload accepted this cycle when tx_valid is also high
//   tx       - registered serial line, idles high
//   busy     - a frame is in progress
//   ack_sent - one-cycle pulse in the final stop-bit cycle of an ACK frame
module uart_ack_tx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter logic [7:0]  ACK_BYTE   = ACK_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ack_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       ack_sent
);

  localparam int unsigned TickW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned DataBits = FRAME_BITS - 2;

  uart_state_e      state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ack_prev_q;
  logic             pend_q, pend_d;
  logic             is_ack_q, is_ack_d;
  logic             ack_rise;
  logic             consume;
  logic             tick_last;

  assign ack_rise  = ack_in & ~ack_prev_q;
  assign tick_last = (tick_q == TickW'(OVERSAMPLE - 1));

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    is_ack_d = is_ack_q;
    consume  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (pend_q) begin
          shift_d  = ACK_BYTE;
          is_ack_d = 1'b1;
          consume  = 1'b1;
          state_d  = START;
        end else if (tx_valid) begin
          shift_d  = tx_data;
          is_ack_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_d = '0;
          if (bit_q == 3'(DataBits - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      STOP: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = IDLE;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge as the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    // A new edge in the consuming cycle must not be lost: set beats clear.
    pend_d = ack_rise | (pend_q & ~consume);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ack_prev_q <= 1'b1;  // ack_in held high across reset must not look like an edge
      pend_q     <= 1'b0;
      is_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ack_prev_q <= ack_in;
      pend_q     <= pend_d;
      is_ack_q   <= is_ack_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign tx_ready = (state_q == IDLE) & ~pend_q;
  assign ack_sent = (state_q == STOP) & tick_last & is_ack_q;

endmodule

// File: tb/tb_uart_ack_tx.sv
// Scoreboard bench for uart_ack_tx: stimulus pushes expected frames, a negedge monitor
// decodes the serial line cycle by cycle and pops/compares at each frame.
module tb_uart_ack_tx;

  localparam int unsigned Os       = 16;
  localparam int unsigned FrameCyc = 10 * Os;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack_in = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, ack_sent;

  uart_ack_tx #(.OVERSAMPLE(Os), .ACK_BYTE(8'h06)) dut (
    .clk      (clk),
    .rst      (rst),
    .ack_in   (ack_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .ack_sent (ack_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         is_ack;
    int         gap;    // required idle-line cycles before this frame, 0 = don't care
    bit         abort;  // frame is expected to be cut by reset
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acks_exp = 0;
  int   acks_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    int b;
    b = idx / Os;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // ---------------- monitor ----------------
  bit         in_frame = 0;
  int         idx = 0;
  int         gap = 0;
  bit         line_ok, ack_ok;
  logic [7:0] rx_byte;
  exp_t       cur;

  always @(negedge clk) begin
    if (ack_sent === 1'b1) acks_seen++;
    if (rst) begin
      if (in_frame) chk("frame cut by reset was expected to complete", 1, int'(cur.abort));
      in_frame = 0;
      gap = 0;
    end else begin
      if (!in_frame) begin
        if (tx === 1'b0) begin
          if (sb.size() == 0) begin
            chk("unexpected frame start", 1, 0);
            cur = '{data: 8'h00, is_ack: 1'b0, gap: 0, abort: 1'b0};
          end else begin
            cur = sb.pop_front();
          end
          if (cur.gap != 0) chk("inter-frame idle cycles", gap, cur.gap);
          in_frame = 1;
          idx = 0;
          line_ok = 1;
          ack_ok = 1;
          rx_byte = 8'h00;
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        if (tx !== frame_bit(cur.data, idx)) line_ok = 0;
        if (ack_sent !== ((idx == FrameCyc - 1) && cur.is_ack)) ack_ok = 0;
        if ((idx % Os) == Os / 2 && idx / Os >= 1 && idx / Os <= 8) rx_byte[idx/Os-1] = tx;
        idx++;
        if (idx == FrameCyc) begin
          chk("frame byte", int'(rx_byte), int'(cur.data));
          chk("frame line shape/timing", int'(line_ok), 1);
          chk("ack_sent pulse position", int'(ack_ok), 1);
          if (cur.abort) chk("frame expected to be aborted", 0, 1);
          in_frame = 0;
          gap = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit a, input int g, input bit ab);
    sb.push_back('{data: d, is_ack: a, gap: g, abort: ab});
    if (a && !ab) acks_exp++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && tx_ready === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk({name, " idle timeout"}, 0, 1);
  endtask

  // Waits for a cycle with tx_ready, then returns just after the accepting edge.
  task automatic wait_accept(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk({name, " accept timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit bad;

    // reset state
    step(3);
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset ack_sent", int'(ack_sent), 0);
    rst = 1'b0;
    step(1);
    chk("post-reset tx_ready", int'(tx_ready), 1);
    step(2);

    // idle ACK: tx falls at second edge after ack_in first sampled high
    push(8'h06, 1, 0, 0);
    ack_in = 1'b1;
    step(1);
    chk("ack latency edge1 tx", int'(tx), 1);
    chk("ack pending blocks tx_ready", int'(tx_ready), 0);
    step(1);
    chk("ack latency edge2 tx", int'(tx), 0);
    chk("ack frame busy", int'(busy), 1);
    wait_idle("idle ack", 400);

    // payload 0xA5
    ack_in = 1'b0;
    step(2);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    chk("payload tx_ready in idle", int'(tx_ready), 1);
    push(8'hA5, 0, 0, 0);
    step(1);
    tx_valid = 1'b0;
    tx_data = 8'h00;  // must be ignored from here on
    bad = 0;
    for (int i = 0; i < FrameCyc - 1; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    chk("tx_ready low/busy high during payload", int'(bad), 0);
    wait_idle("payload", 400);

    // collision: ACK during payload with tx_valid still high
    step(2);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    push(8'hA5, 0, 0, 0);
    wait_accept("collision first", 50);
    step(40);
    ack_in = 1'b1;
    push(8'h06, 1, 1, 0);
    step(2);
    ack_in = 1'b0;
    push(8'hA5, 0, 1, 0);
    wait_accept("collision second", 800);
    tx_valid = 1'b0;
    wait_idle("collision", 400);

    // coalescing: three pulses during one payload frame
    step(3);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    push(8'h5A, 0, 0, 0);
    wait_accept("coalesce", 50);
    tx_valid = 1'b0;
    step(20);
    for (int k = 0; k < 3; k++) begin
      ack_in = 1'b1;
      step(2);
      ack_in = 1'b0;
      step(2);
    end
    push(8'h06, 1, 1, 0);
    wait_idle("coalesce", 800);
    chk("ack_sent count so far", acks_seen, acks_exp);

    // reset in data bit 4 with an ACK pending
    step(3);
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    push(8'h0F, 0, 0, 1);
    wait_accept("reset frame", 50);
    tx_valid = 1'b0;
    step(2);
    ack_in = 1'b1;
    step(83);
    chk("bit 4 of 0x0F before reset", int'(tx), 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async reset tx", int'(tx), 1);
    chk("async reset busy", int'(busy), 0);
    chk("async reset ack_sent", int'(ack_sent), 0);
    step(3);
    rst = 1'b0;
    step(1);
    chk("after reset tx_ready", int'(tx_ready), 1);
    chk("after reset busy", int'(busy), 0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || ack_sent !== 1'b0) bad = 1;
    end
    chk("no stray frame after reset", int'(bad), 0);

    // fresh edge after reset still produces an ACK
    step(1);
    ack_in = 1'b0;
    step(3);
    push(8'h06, 1, 0, 0);
    ack_in = 1'b1;
    step(4);
    wait_idle("post-reset ack", 400);
    step(2);

    chk("ack_sent total", acks_seen, acks_exp);
    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_ack_tx.md
UART_ACK_TX -- requirements
Module: uart_ack_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: clk cycles per UART bit.
REQ-002 Parameter ACK_BYTE, default 8'h06: byte transmitted for each acknowledge event.
REQ-003 clk  input  1  UART sampling clock, 16x baud; the module's only clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ack_in  input  1  acknowledge level, already synchronized into the clk domain by the upstream synchronizer.
REQ-006 tx_data  input  8  general payload byte.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  module accepts tx_data this cycle.
REQ-009 tx  output  1  serial line, 8N1, idles high, registered.
REQ-010 busy  output  1  a frame is in progress (state != IDLE).
REQ-011 ack_sent  output  1  one-cycle pulse when an ACK frame's stop bit completes.

Function
REQ-012 The module SHALL register ack_in into ack_prev and detect a rising edge as ack_in & ~ack_prev.
REQ-013 A rising edge SHALL set ack_pending; if the edge coincides with consumption of ack_pending, set wins and ack_pending stays 1.
REQ-014 Further edges while ack_pending=1 SHALL coalesce into one ACK frame.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 In IDLE with ack_pending=1: load ACK_BYTE, clear ack_pending, go to START. ACK has priority over tx_valid.
REQ-017 In IDLE with ack_pending=0 and tx_valid=1: load tx_data, go to START. The handshake completes when tx_valid & tx_ready.
REQ-018 tx_ready SHALL be combinational: (state==IDLE) & ~ack_pending.
REQ-019 Each bit SHALL last exactly OVERSAMPLE cycles, timed by a tick counter 0..OVERSAMPLE-1.
REQ-020 Bit order: START (tx=0), DATA bits 0..7 LSB first, STOP (tx=1).
REQ-021 Each frame SHALL last 10*OVERSAMPLE cycles (160 at default).
REQ-022 On the last STOP tick, the FSM SHALL return to IDLE. At least one IDLE cycle SHALL separate frames.
REQ-023 Latency from idle: tx falls at the second rising clk edge after ack_in is first sampled high.
REQ-024 ack_sent SHALL pulse for one cycle on the STOP-to-IDLE transition of an ACK frame only, never for a payload frame.
REQ-025 A rising edge during a payload frame SHALL be held pending and sent immediately after that frame.
REQ-026 tx_data SHALL be ignored outside the accepting cycle; the shift register holds the frame byte.

Reset
REQ-027 Reset values: tx=1, state=IDLE, busy=0, ack_sent=0, ack_pending=0, tick and bit counters 0, shift register 0.
REQ-028 ack_prev SHALL reset to 1, so an ack_in held high through reset release generates no frame.
REQ-029 Reset mid-frame SHALL abort the frame: tx high asynchronously, no ack_sent pulse, pending ACK discarded.
REQ-030 After reset release, tx_ready=1.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), the OVERSAMPLE default, the ACK_BYTE default and FRAME_BITS=10.
REQ-032 The design SHALL be a single module with no sub-module; edge detect, FSM, tick/bit counters and shift register are inline.

Verification
REQ-033 Idle ACK: ack_in 0->1 held -> tx low at 2nd edge; line carries 0,0,1,1,0,0,0,0,0,1 (start, 0x06 LSB-first, stop), 16 cycles each; ack_sent pulses once at cycle 160 of the frame.
REQ-034 Payload: tx_data=8'hA5, tx_valid=1 -> accepted in 1 cycle; frame bits 0,1,0,1,0,0,1,0,1,1; tx_ready=0 for the whole frame; no ack_sent.
REQ-035 Priority/collision: ack_in rises while a 0xA5 frame is active, tx_valid still high -> after 0xA5 stop and 1 idle cycle, 0x06 frame precedes the next payload.
REQ-036 Coalescing: three ack_in pulses (2 cycles high, 2 low) during one frame -> exactly one ACK frame and one ack_sent.
REQ-037 Reset mid-DATA: rst asserted at bit 4 -> tx=1 immediately; after release, busy=0, tx_ready=1, no stray frame although ack_in=1.
